mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 146 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency HI/LO update (mult 5 cycles, div 10 cycles) plus mthi/mtlo.
// Build option MDU_DIV0_GUARD_EN: divide-by-zero leaves HI/LO unchanged instead of writing HI=A, LO=all-ones.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiLoSel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_phi;
  logic [31:0] r_plo;

  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [31:0] w_divisor;
  logic [63:0] w_div;
  logic [31:0] w_phi;
  logic [31:0] w_plo;
  logic        w_launch;

  // Division on magnitudes; returns {remainder, quotient}. The INT_MIN / -1 case falls out as 0x80000000 rem 0.
  function automatic logic [63:0] div_result(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    ua = (sgn && a[31]) ? (32'd0 - a) : a;
    ub = (sgn && b[31]) ? (32'd0 - b) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (sgn && (a[31] ^ b[31])) begin
      q = 32'd0 - q;
    end
    if (sgn && a[31]) begin
      r = 32'd0 - r;
    end
    return {r, q};
  endfunction

  assign w_sprod   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_uprod   = {32'd0, A} * {32'd0, B};
  assign w_divisor = (B == 32'd0) ? 32'd1 : B;
  assign w_div     = div_result(MDUOp == OP_DIV, A, w_divisor);
  assign w_launch  = Start && (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);

  // Pending result selection for the operation being launched
  always_comb begin
    w_phi = r_phi;
    w_plo = r_plo;
    case (MDUOp)
      OP_MULT:  {w_phi, w_plo} = w_sprod;
      OP_MULTU: {w_phi, w_plo} = w_uprod;
      OP_DIV, OP_DIVU: begin
        if (B == 32'd0) begin
`ifdef MDU_DIV0_GUARD_EN
          w_phi = r_hi;
          w_plo = r_lo;
`else
          w_phi = A;
          w_plo = 32'hFFFF_FFFF;
`endif
        end else begin
          {w_phi, w_plo} = w_div;
        end
      end
      default: begin
        w_phi = r_phi;
        w_plo = r_plo;
      end
    endcase
  end

  // Control FSM, latency counter and architectural HI/LO
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_phi   <= w_phi;
            r_plo   <= w_plo;
            r_cnt   <= (MDUOp <= OP_MULTU) ? 4'd5 : 4'd10;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else if (MDUOp == OP_MTHI) begin
            r_hi <= A;
          end else if (MDUOp == OP_MTLO) begin
            r_lo <= A;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_hi    <= r_phi;
            r_lo    <= r_plo;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_busy <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign Busy  = r_busy;
  assign HI    = r_hi;
  assign LO    = r_lo;
  assign MDOut = HiLoSel ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl; expected values are hand-computed constants.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset_n;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        HiLoSel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  int n_tests;
  int n_fail;
  int cyc;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Start   (Start),
    .MDUOp   (MDUOp),
    .A       (A),
    .B       (B),
    .HiLoSel (HiLoSel),
    .Busy    (Busy),
    .HI      (HI),
    .LO      (LO),
    .MDOut   (MDOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Launch an op, count busy cycles (bounded), optionally inject Start then mthi mid-run.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, output int cycles);
    Start = 1'b1; MDUOp = op; A = a; B = b; HiLoSel = 1'b1;
    #1;
    check("busy_in_start_cycle", {31'd0, Busy}, 32'd0);
    tick();
    Start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0;
    cycles = 0;
    while (Busy === 1'b1 && cycles < 20) begin
      if (cycles == 0) begin
        check("mdout_pre_op_hi", MDOut, exp_hi);
        check("lo_pre_op", LO, exp_lo);
      end
      if (cycles == inject_at) begin
        Start = 1'b1; MDUOp = 3'd1; A = 32'h0000_DEAD; B = 32'd2;
      end else if (cycles == inject_at + 1) begin
        Start = 1'b0; MDUOp = 3'd5;
      end else begin
        Start = 1'b0; MDUOp = 3'd0;
      end
      cycles++;
      tick();
    end
    Start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; Start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0; HiLoSel = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;

    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_mdout", MDOut, 32'd0);

    // mult -2 * 3
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, -1, cyc);
    check("mult_cycles", cyc, 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFA;

    // multu same operands
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, -1, cyc);
    check("multu_cycles", cyc, 32'd5);
    check("multu_hi", HI, 32'h0000_0002);
    check("multu_lo", LO, 32'hFFFF_FFFA);
    exp_hi = 32'h0000_0002; exp_lo = 32'hFFFF_FFFA;

    // div -7 / 2 with a Start pulse in RUN cycle 4 and an mthi after it
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 3, cyc);
    check("div_cycles", cyc, 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    tick();
    check("div_no_reentry", {31'd0, Busy}, 32'd0);
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;

    // div 7 / -2: remainder follows sign of dividend
    run_op(3'd3, 32'd7, 32'hFFFF_FFFE, -1, cyc);
    check("div2_lo", LO, 32'hFFFF_FFFD);
    check("div2_hi", HI, 32'h0000_0001);
    exp_hi = 32'h0000_0001; exp_lo = 32'hFFFF_FFFD;

    // mthi (with Start asserted: must not enter RUN), then mtlo
    Start = 1'b1; MDUOp = 3'd5; A = 32'h1234_5678;
    tick();
    check("mthi_no_run", {31'd0, Busy}, 32'd0);
    Start = 1'b0; MDUOp = 3'd6; A = 32'h9ABC_DEF0;
    tick();
    MDUOp = 3'd0; A = 32'd0;
    HiLoSel = 1'b1; #1;
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_mdout", MDOut, 32'h1234_5678);
    HiLoSel = 1'b0; #1;
    check("mtlo_mdout", MDOut, 32'h9ABC_DEF0);
    exp_hi = 32'h1234_5678; exp_lo = 32'h9ABC_DEF0;

    // Start with reserved op 7 must not enter RUN
    Start = 1'b1; MDUOp = 3'd7; A = 32'd9; B = 32'd3;
    tick();
    Start = 1'b0; MDUOp = 3'd0;
    check("op7_no_run", {31'd0, Busy}, 32'd0);
    check("op7_hi", HI, 32'h1234_5678);

    // signed overflow divide
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, cyc);
    check("ovf_cycles", cyc, 32'd10);
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'h0000_0000);

    // divu aborted by reset in RUN cycle 6
    Start = 1'b1; MDUOp = 3'd4; A = 32'd100; B = 32'd7;
    tick();
    Start = 1'b0; MDUOp = 3'd0;
    cyc = 0;
    while (Busy === 1'b1 && cyc < 5) begin
      cyc++;
      tick();
    end
    check("abort_busy_pre", {31'd0, Busy}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("abort_late_hi", HI, 32'd0);
    check("abort_late_lo", LO, 32'd0);

    // divu by zero from a known HI/LO
    MDUOp = 3'd5; A = 32'h1111_1111; tick();
    MDUOp = 3'd6; A = 32'h2222_2222; tick();
    MDUOp = 3'd0;
    exp_hi = 32'h1111_1111; exp_lo = 32'h2222_2222;
    run_op(3'd4, 32'd5, 32'd0, -1, cyc);
    check("div0_cycles", cyc, 32'd10);
`ifdef MDU_DIV0_GUARD_EN
    check("div0_hi", HI, 32'h1111_1111);
    check("div0_lo", LO, 32'h2222_2222);
`else
    check("div0_hi", HI, 32'h0000_0005);
    check("div0_lo", LO, 32'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
